// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions: widths, ALU op encodings and the ID/EX payload.
// Also holds the forwarding-match helper used by the ID/EX stage.
package riscv_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_MUL  = 4'b1010,
        ALU_MULH = 4'b1011,
        ALU_DIV  = 4'b1100,
        ALU_REM  = 4'b1101
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        alu_op_e               alu_op;
        logic                  op1_sel;
        logic                  op2_sel;
        logic                  reg_write;
        logic                  mem_read;
    } id_ex_payload_t;

    // A later-stage result is usable for rs when that stage writes a non-x0 rd equal to rs.
    function automatic logic fwd_match(input logic                  reg_write,
                                       input logic [REG_ADDR_W-1:0] rd,
                                       input logic [REG_ADDR_W-1:0] rs);
        return reg_write && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding mux: MEM result beats WB result beats register-file data.
// Index x0 always yields zero.
module fwd_mux
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [XLEN-1:0]       i_reg_data,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_mem_reg_write,
    input  logic [XLEN-1:0]       i_mem_result,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic                  i_wb_reg_write,
    input  logic [XLEN-1:0]       i_wb_result,
    output logic [XLEN-1:0]       o_value
);

    always_comb begin
        o_value = i_reg_data;
        if (i_rs == '0) begin
            o_value = '0;
        end else if (fwd_match(i_mem_reg_write, i_mem_rd, i_rs)) begin
            o_value = i_mem_result;
        end else if (fwd_match(i_wb_reg_write, i_wb_rd, i_rs)) begin
            o_value = i_wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and MEM/WB operand forwarding.
// One payload slot; operands are formed combinationally from the registered slot.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid_in,
    output logic                  id_ready_out,
    input  logic [XLEN-1:0]       id_pc_in,
    input  logic [XLEN-1:0]       id_rs1_data_in,
    input  logic [XLEN-1:0]       id_rs2_data_in,
    input  logic [REG_ADDR_W-1:0] id_rs1_in,
    input  logic [REG_ADDR_W-1:0] id_rs2_in,
    input  logic [REG_ADDR_W-1:0] id_rd_in,
    input  logic [XLEN-1:0]       id_imm_in,
    input  logic [3:0]            id_alu_op_in,
    input  logic                  id_op1_sel_in,
    input  logic                  id_op2_sel_in,
    input  logic                  id_reg_write_in,
    input  logic                  id_mem_read_in,
    input  logic                  flush_in,
    input  logic                  ex_ready_in,
    input  logic [REG_ADDR_W-1:0] mem_rd_in,
    input  logic                  mem_reg_write_in,
    input  logic                  mem_is_load_in,
    input  logic [XLEN-1:0]       mem_result_in,
    input  logic [REG_ADDR_W-1:0] wb_rd_in,
    input  logic                  wb_reg_write_in,
    input  logic [XLEN-1:0]       wb_result_in,
    output logic                  ex_valid_out,
    output logic [XLEN-1:0]       ex_operand1_out,
    output logic [XLEN-1:0]       ex_operand2_out,
    output logic [3:0]            ex_alu_op_out,
    output logic [XLEN-1:0]       ex_store_data_out,
    output logic [REG_ADDR_W-1:0] ex_rd_out,
    output logic                  ex_reg_write_out,
    output logic                  ex_mem_read_out
);

    logic           r_slot_valid;
    id_ex_payload_t r_slot;

    logic           w_hazard;
    logic           w_capture;
    logic           w_advance;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    id_ex_payload_t w_id_payload;

    // A load still in MEM cannot forward yet, so a dependent slot must wait one cycle.
    assign w_hazard = r_slot_valid && mem_is_load_in &&
                      (fwd_match(mem_reg_write_in, mem_rd_in, r_slot.rs1) ||
                       fwd_match(mem_reg_write_in, mem_rd_in, r_slot.rs2));

    assign id_ready_out = !r_slot_valid || (ex_ready_in && !w_hazard);
    assign ex_valid_out = r_slot_valid && !w_hazard;
    assign w_advance    = ex_valid_out && ex_ready_in;
    assign w_capture    = id_valid_in && id_ready_out && !flush_in;

    always_comb begin
        w_id_payload           = '0;
        w_id_payload.pc        = id_pc_in;
        w_id_payload.rs1_data  = id_rs1_data_in;
        w_id_payload.rs2_data  = id_rs2_data_in;
        w_id_payload.imm       = id_imm_in;
        w_id_payload.rs1       = id_rs1_in;
        w_id_payload.rs2       = id_rs2_in;
        w_id_payload.rd        = id_rd_in;
        w_id_payload.alu_op    = alu_op_e'(id_alu_op_in);
        w_id_payload.op1_sel   = id_op1_sel_in;
        w_id_payload.op2_sel   = id_op2_sel_in;
        w_id_payload.reg_write = id_reg_write_in;
        w_id_payload.mem_read  = id_mem_read_in;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_slot_valid <= 1'b0;
            r_slot       <= '0;
        end else if (flush_in) begin
            r_slot_valid <= 1'b0;
        end else if (w_capture) begin
            r_slot_valid <= 1'b1;
            r_slot       <= w_id_payload;
        end else if (w_advance) begin
            r_slot_valid <= 1'b0;
        end
    end

    fwd_mux u_fwd_rs1 (
        .i_rs            (r_slot.rs1),
        .i_reg_data      (r_slot.rs1_data),
        .i_mem_rd        (mem_rd_in),
        .i_mem_reg_write (mem_reg_write_in),
        .i_mem_result    (mem_result_in),
        .i_wb_rd         (wb_rd_in),
        .i_wb_reg_write  (wb_reg_write_in),
        .i_wb_result     (wb_result_in),
        .o_value         (w_fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .i_rs            (r_slot.rs2),
        .i_reg_data      (r_slot.rs2_data),
        .i_mem_rd        (mem_rd_in),
        .i_mem_reg_write (mem_reg_write_in),
        .i_mem_result    (mem_result_in),
        .i_wb_rd         (wb_rd_in),
        .i_wb_reg_write  (wb_reg_write_in),
        .i_wb_result     (wb_result_in),
        .o_value         (w_fwd_rs2)
    );

    assign ex_operand1_out   = r_slot.op1_sel ? r_slot.pc  : w_fwd_rs1;
    assign ex_operand2_out   = r_slot.op2_sel ? r_slot.imm : w_fwd_rs2;
    assign ex_store_data_out = w_fwd_rs2;
    assign ex_alu_op_out     = r_slot.alu_op;
    assign ex_rd_out         = r_slot.rd;
    assign ex_reg_write_out  = r_slot.reg_write;
    assign ex_mem_read_out   = r_slot.mem_read;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, pass-through, forwarding,
// load-use stall, backpressure, flush, mid-run reset and back-to-back issue.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid_in;
    logic        id_ready_out;
    logic [63:0] id_pc_in, id_rs1_data_in, id_rs2_data_in, id_imm_in;
    logic [4:0]  id_rs1_in, id_rs2_in, id_rd_in;
    logic [3:0]  id_alu_op_in;
    logic        id_op1_sel_in, id_op2_sel_in, id_reg_write_in, id_mem_read_in;
    logic        flush_in, ex_ready_in;
    logic [4:0]  mem_rd_in, wb_rd_in;
    logic        mem_reg_write_in, mem_is_load_in, wb_reg_write_in;
    logic [63:0] mem_result_in, wb_result_in;
    logic        ex_valid_out;
    logic [63:0] ex_operand1_out, ex_operand2_out, ex_store_data_out;
    logic [3:0]  ex_alu_op_out;
    logic [4:0]  ex_rd_out;
    logic        ex_reg_write_out, ex_mem_read_out;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .id_valid_in       (id_valid_in),
        .id_ready_out      (id_ready_out),
        .id_pc_in          (id_pc_in),
        .id_rs1_data_in    (id_rs1_data_in),
        .id_rs2_data_in    (id_rs2_data_in),
        .id_rs1_in         (id_rs1_in),
        .id_rs2_in         (id_rs2_in),
        .id_rd_in          (id_rd_in),
        .id_imm_in         (id_imm_in),
        .id_alu_op_in      (id_alu_op_in),
        .id_op1_sel_in     (id_op1_sel_in),
        .id_op2_sel_in     (id_op2_sel_in),
        .id_reg_write_in   (id_reg_write_in),
        .id_mem_read_in    (id_mem_read_in),
        .flush_in          (flush_in),
        .ex_ready_in       (ex_ready_in),
        .mem_rd_in         (mem_rd_in),
        .mem_reg_write_in  (mem_reg_write_in),
        .mem_is_load_in    (mem_is_load_in),
        .mem_result_in     (mem_result_in),
        .wb_rd_in          (wb_rd_in),
        .wb_reg_write_in   (wb_reg_write_in),
        .wb_result_in      (wb_result_in),
        .ex_valid_out      (ex_valid_out),
        .ex_operand1_out   (ex_operand1_out),
        .ex_operand2_out   (ex_operand2_out),
        .ex_alu_op_out     (ex_alu_op_out),
        .ex_store_data_out (ex_store_data_out),
        .ex_rd_out         (ex_rd_out),
        .ex_reg_write_out  (ex_reg_write_out),
        .ex_mem_read_out   (ex_mem_read_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [63:0] pc, input logic [4:0] rs1, input logic [63:0] rs1d,
                             input logic [4:0] rs2, input logic [63:0] rs2d, input logic [4:0] rd,
                             input logic [63:0] imm, input logic [3:0] op,
                             input logic s1, input logic s2);
        id_valid_in     = 1'b1;
        id_pc_in        = pc;
        id_rs1_in       = rs1;
        id_rs1_data_in  = rs1d;
        id_rs2_in       = rs2;
        id_rs2_data_in  = rs2d;
        id_rd_in        = rd;
        id_imm_in       = imm;
        id_alu_op_in    = op;
        id_op1_sel_in   = s1;
        id_op2_sel_in   = s2;
        id_reg_write_in = 1'b1;
        id_mem_read_in  = 1'b0;
    endtask

    task automatic clear_fwd;
        mem_rd_in = '0; mem_reg_write_in = 1'b0; mem_is_load_in = 1'b0; mem_result_in = '0;
        wb_rd_in  = '0; wb_reg_write_in  = 1'b0; wb_result_in = '0;
    endtask

    task automatic drain;
        id_valid_in = 1'b0;
        ex_ready_in = 1'b1;
        flush_in    = 1'b0;
        clear_fwd();
        tick();
    endtask

    task automatic test_reset;
        reset_n = 1'b0; flush_in = 1'b0; ex_ready_in = 1'b1; clear_fwd();
        set_instr(64'h40, 5'd1, 64'h123, 5'd2, 64'h456, 5'd9, 64'h7, 4'd3, 1'b0, 1'b0);
        tick(); tick();
        vectors++;
        if (ex_valid_out !== 1'b0) begin
            $display("FAIL reset_valid: got %b, expected 0", ex_valid_out); miscompares++;
        end
        vectors++;
        if (ex_alu_op_out !== 4'd0) begin
            $display("FAIL reset_alu_op: got %h, expected 0", ex_alu_op_out); miscompares++;
        end
        vectors++;
        if (ex_rd_out !== 5'd0 || ex_operand2_out !== 64'd0 || ex_reg_write_out !== 1'b0) begin
            $display("FAIL reset_payload: got rd=%0d op2=%h rw=%b, expected 0", ex_rd_out, ex_operand2_out, ex_reg_write_out);
            miscompares++;
        end
        reset_n = 1'b1; id_valid_in = 1'b0;
        #1;
        vectors++;
        if (id_ready_out !== 1'b1) begin
            $display("FAIL reset_ready: got %b, expected 1", id_ready_out); miscompares++;
        end
        $display("test_reset done");
    endtask

    task automatic test_basic;
        set_instr(64'h100, 5'd1, 64'd5, 5'd2, 64'd99, 5'd6, 64'd7, 4'd0, 1'b0, 1'b1);
        tick();
        id_valid_in = 1'b0;
        #1;
        vectors++;
        if (ex_valid_out !== 1'b1 || ex_operand1_out !== 64'd5 || ex_operand2_out !== 64'd7) begin
            $display("FAIL basic_operands: got v=%b op1=%h op2=%h, expected v=1 op1=5 op2=7", ex_valid_out, ex_operand1_out, ex_operand2_out);
            miscompares++;
        end
        vectors++;
        if (ex_rd_out !== 5'd6 || ex_store_data_out !== 64'd99 || ex_alu_op_out !== 4'd0) begin
            $display("FAIL basic_ctrl: got rd=%0d sd=%h op=%h, expected rd=6 sd=63 op=0", ex_rd_out, ex_store_data_out, ex_alu_op_out);
            miscompares++;
        end
        tick();
        vectors++;
        if (ex_valid_out !== 1'b0) begin
            $display("FAIL basic_retire: got %b, expected 0", ex_valid_out); miscompares++;
        end
        $display("test_basic done");
    endtask

    task automatic test_forward;
        ex_ready_in = 1'b1;
        set_instr(64'h200, 5'd3, 64'h11, 5'd0, 64'h0, 5'd1, 64'h0, 4'd0, 1'b0, 1'b0);
        tick();
        id_valid_in = 1'b0; ex_ready_in = 1'b0;
        mem_rd_in = 5'd3; mem_reg_write_in = 1'b1; mem_result_in = 64'hAA;
        wb_rd_in  = 5'd3; wb_reg_write_in  = 1'b1; wb_result_in  = 64'hBB;
        #1;
        vectors++;
        if (ex_operand1_out !== 64'hAA) begin
            $display("FAIL fwd_mem_prio: got %h, expected aa", ex_operand1_out); miscompares++;
        end
        mem_reg_write_in = 1'b0;
        #1;
        vectors++;
        if (ex_operand1_out !== 64'hBB) begin
            $display("FAIL fwd_wb: got %h, expected bb", ex_operand1_out); miscompares++;
        end
        wb_reg_write_in = 1'b0;
        #1;
        vectors++;
        if (ex_operand1_out !== 64'h11) begin
            $display("FAIL fwd_none: got %h, expected 11", ex_operand1_out); miscompares++;
        end
        ex_ready_in = 1'b1;
        set_instr(64'h204, 5'd0, 64'h55, 5'd5, 64'h22, 5'd2, 64'h33, 4'd4, 1'b0, 1'b1);
        tick();
        id_valid_in = 1'b0; ex_ready_in = 1'b0;
        mem_rd_in = 5'd0; mem_reg_write_in = 1'b1; mem_result_in = 64'hAA;
        wb_rd_in  = 5'd0; wb_reg_write_in  = 1'b1;
        #1;
        vectors++;
        if (ex_operand1_out !== 64'h0) begin
            $display("FAIL fwd_x0: got %h, expected 0", ex_operand1_out); miscompares++;
        end
        wb_rd_in = 5'd5;
        #1;
        vectors++;
        if (ex_store_data_out !== 64'hBB || ex_operand2_out !== 64'h33) begin
            $display("FAIL fwd_store: got sd=%h op2=%h, expected sd=bb op2=33", ex_store_data_out, ex_operand2_out);
            miscompares++;
        end
        drain();
        $display("test_forward done");
    endtask

    task automatic test_load_use;
        ex_ready_in = 1'b1;
        set_instr(64'h300, 5'd0, 64'h0, 5'd4, 64'h99, 5'd11, 64'h0, 4'd1, 1'b0, 1'b0);
        tick();
        set_instr(64'h304, 5'd0, 64'h0, 5'd0, 64'h0, 5'd12, 64'h0, 4'd2, 1'b0, 1'b0);
        mem_rd_in = 5'd4; mem_reg_write_in = 1'b1; mem_is_load_in = 1'b1; mem_result_in = 64'hDEAD;
        #1;
        vectors++;
        if (ex_valid_out !== 1'b0 || id_ready_out !== 1'b0) begin
            $display("FAIL loaduse_stall: got v=%b rdy=%b, expected v=0 rdy=0", ex_valid_out, id_ready_out);
            miscompares++;
        end
        tick();
        clear_fwd();
        wb_rd_in = 5'd4; wb_reg_write_in = 1'b1; wb_result_in = 64'h10;
        #1;
        vectors++;
        if (ex_valid_out !== 1'b1 || ex_operand2_out !== 64'h10 || ex_rd_out !== 5'd11) begin
            $display("FAIL loaduse_release: got v=%b op2=%h rd=%0d, expected v=1 op2=10 rd=11", ex_valid_out, ex_operand2_out, ex_rd_out);
            miscompares++;
        end
        tick();
        id_valid_in = 1'b0; clear_fwd();
        #1;
        vectors++;
        if (ex_valid_out !== 1'b1 || ex_rd_out !== 5'd12) begin
            $display("FAIL loaduse_next: got v=%b rd=%0d, expected v=1 rd=12", ex_valid_out, ex_rd_out);
            miscompares++;
        end
        drain();
        $display("test_load_use done");
    endtask

    task automatic test_backpressure;
        ex_ready_in = 1'b1;
        set_instr(64'h1000, 5'd0, 64'h0, 5'd0, 64'h0, 5'd7, 64'h0, 4'd0, 1'b1, 1'b0);
        tick();
        ex_ready_in = 1'b0;
        set_instr(64'h2000, 5'd0, 64'h0, 5'd0, 64'h0, 5'd8, 64'h0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (id_ready_out !== 1'b0 || ex_valid_out !== 1'b1 || ex_rd_out !== 5'd7 || ex_operand1_out !== 64'h1000) begin
                $display("FAIL bp_hold%0d: got rdy=%b v=%b rd=%0d op1=%h, expected rdy=0 v=1 rd=7 op1=1000", i, id_ready_out, ex_valid_out, ex_rd_out, ex_operand1_out);
                miscompares++;
            end
            tick();
        end
        ex_ready_in = 1'b1;
        #1;
        vectors++;
        if (id_ready_out !== 1'b1) begin
            $display("FAIL bp_release_ready: got %b, expected 1", id_ready_out); miscompares++;
        end
        tick();
        id_valid_in = 1'b0;
        #1;
        vectors++;
        if (ex_valid_out !== 1'b1 || ex_rd_out !== 5'd8 || ex_operand1_out !== 64'h2000) begin
            $display("FAIL bp_next: got v=%b rd=%0d op1=%h, expected v=1 rd=8 op1=2000", ex_valid_out, ex_rd_out, ex_operand1_out);
            miscompares++;
        end
        tick();
        vectors++;
        if (ex_valid_out !== 1'b0) begin
            $display("FAIL bp_no_dup: got %b, expected 0", ex_valid_out); miscompares++;
        end
        $display("test_backpressure done");
    endtask

    task automatic test_flush;
        ex_ready_in = 1'b1;
        set_instr(64'h500, 5'd0, 64'h0, 5'd0, 64'h0, 5'd9, 64'h0, 4'd0, 1'b0, 1'b0);
        tick();
        set_instr(64'h504, 5'd0, 64'h0, 5'd0, 64'h0, 5'd10, 64'h0, 4'd0, 1'b0, 1'b0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0; id_valid_in = 1'b0;
        #1;
        vectors++;
        if (ex_valid_out !== 1'b0) begin
            $display("FAIL flush_kill: got %b rd=%0d, expected valid 0", ex_valid_out, ex_rd_out); miscompares++;
        end
        tick();
        vectors++;
        if (ex_valid_out !== 1'b0) begin
            $display("FAIL flush_no_issue: got %b, expected 0", ex_valid_out); miscompares++;
        end
        $display("test_flush done");
    endtask

    task automatic test_mid_reset;
        ex_ready_in = 1'b1;
        set_instr(64'h600, 5'd1, 64'h77, 5'd0, 64'h0, 5'd13, 64'h0, 4'd6, 1'b0, 1'b0);
        tick();
        id_valid_in = 1'b0; ex_ready_in = 1'b0; reset_n = 1'b0; flush_in = 1'b1;
        tick();
        reset_n = 1'b1; flush_in = 1'b0;
        #1;
        vectors++;
        if (ex_valid_out !== 1'b0 || ex_rd_out !== 5'd0 || ex_alu_op_out !== 4'd0 || ex_operand1_out !== 64'd0) begin
            $display("FAIL mid_reset: got v=%b rd=%0d op=%h op1=%h, expected all 0", ex_valid_out, ex_rd_out, ex_alu_op_out, ex_operand1_out);
            miscompares++;
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_back_to_back;
        ex_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_instr(64'(i * 4), 5'd0, 64'h0, 5'd0, 64'h0, 5'(20 + i), 64'h0, 4'(i), 1'b1, 1'b0);
            tick();
            vectors++;
            if (ex_valid_out !== 1'b1 || ex_rd_out !== 5'(20 + i) || ex_operand1_out !== 64'(i * 4) || ex_alu_op_out !== 4'(i)) begin
                $display("FAIL b2b_%0d: got v=%b rd=%0d op1=%h op=%h, expected v=1 rd=%0d op1=%h op=%h", i, ex_valid_out, ex_rd_out, ex_operand1_out, ex_alu_op_out, 20 + i, i * 4, i);
                miscompares++;
            end
        end
        drain();
        vectors++;
        if (ex_valid_out !== 1'b0) begin
            $display("FAIL b2b_drain: got %b, expected 0", ex_valid_out); miscompares++;
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_load_use();
        test_backpressure();
        test_flush();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
